// File: rtl/led_bar_pkg.sv
// Shared constants and helpers for the LED bar-graph meter.
// Mode and state codes are plain 2-bit constants so they line up with legacy register maps.
package led_bar_pkg;

    typedef logic [1:0] mode_t;
    typedef logic [1:0] state_t;

    localparam mode_t MODE_DIRECT = 2'd0;
    localparam mode_t MODE_RAMP   = 2'd1;
    localparam mode_t MODE_BLINK  = 2'd2;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RISE = 2'd1;
    localparam state_t ST_FALL = 2'd2;

    localparam int MAX_WIDTH = 32;

    // Callers cast the result down to their own bar width.
    function automatic logic [MAX_WIDTH-1:0] thermometer(input logic [5:0] lvl);
        thermometer = ~({MAX_WIDTH{1'b1}} << lvl);
    endfunction

endpackage

// File: rtl/led_bar_meter_tick_gen.sv
// Free-running divider producing a one-cycle registered pulse every TICK_DIV clocks.
module tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count == CNT_MAX) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + CNT_W'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/led_bar_meter.sv
// Thermometer LED bar driver: saturates an offset-biased value into a level and either
// jumps to it or steps one LED per tick, optionally blinking the bar while full.
module led_bar_meter
    import led_bar_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int VAL_W       = 8,
    parameter int OFFSET      = 16,
    parameter int TICK_DIV    = 1_000_000,
    parameter int BLINK_TICKS = 25,
    localparam int LVL_W      = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [VAL_W-1:0]  value,
    input  logic              load,
    input  mode_t             mode,
    output logic [WIDTH-1:0]  led,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              busy
);

    localparam logic [VAL_W:0]   OFF_EXT   = (VAL_W + 1)'(OFFSET);
    localparam logic [VAL_W:0]   WIDTH_EXT = (VAL_W + 1)'(WIDTH);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(WIDTH);
    localparam int               BCNT_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(BLINK_TICKS - 1);

    logic              tick;
    logic [VAL_W:0]    value_ext;
    logic [VAL_W:0]    diff;
    logic [LVL_W-1:0]  sat;
    logic [LVL_W-1:0]  target;
    logic [LVL_W-1:0]  level_nxt;
    state_t            state;
    state_t            state_nxt;
    logic              direct;
    logic              blink_hold;
    logic              blink_count_en;
    logic [BCNT_W-1:0] blink_count;
    logic [BCNT_W-1:0] blink_count_nxt;
    logic              blink_phase;
    logic              blink_phase_nxt;
    logic [WIDTH-1:0]  led_nxt;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // One extra bit keeps value - OFFSET from wrapping for small inputs.
    always_comb begin
        value_ext = {1'b0, value};
        diff      = value_ext - OFF_EXT;
        if (value_ext < OFF_EXT) begin
            sat = '0;
        end else if (diff > WIDTH_EXT) begin
            sat = LVL_FULL;
        end else begin
            sat = LVL_W'(diff);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target <= '0;
        end else if (load) begin
            target <= sat;
        end
    end

    // Reserved mode code 3 falls through to direct behaviour.
    assign direct = (mode != MODE_RAMP) && (mode != MODE_BLINK);

    always_comb begin
        level_nxt = level;
        if (direct) begin
            level_nxt = target;
        end else if (tick && (state == ST_RISE) && (target > level)) begin
            level_nxt = level + LVL_W'(1);
        end else if (tick && (state == ST_FALL) && (target < level)) begin
            level_nxt = level - LVL_W'(1);
        end

        // Direction is re-decided every cycle, so a reversed target never overshoots.
        state_nxt = ST_IDLE;
        if (!direct) begin
            if (target > level_nxt) begin
                state_nxt = ST_RISE;
            end else if (target < level_nxt) begin
                state_nxt = ST_FALL;
            end
        end
    end

    assign blink_hold     = (mode == MODE_BLINK) && (level_nxt == LVL_FULL) && (state_nxt == ST_IDLE);
    assign blink_count_en = tick && full && (state == ST_IDLE);

    always_comb begin
        blink_count_nxt = blink_count;
        blink_phase_nxt = blink_phase;
        if (!blink_hold) begin
            blink_count_nxt = '0;
            blink_phase_nxt = 1'b0;
        end else if (blink_count_en) begin
            if (blink_count == BCNT_MAX) begin
                blink_count_nxt = '0;
                blink_phase_nxt = ~blink_phase;
            end else begin
                blink_count_nxt = blink_count + BCNT_W'(1);
            end
        end
    end

    // Built from next-state values so led and level always agree in the same cycle.
    always_comb begin
        led_nxt = WIDTH'(thermometer(6'(level_nxt)));
        if (blink_phase_nxt) begin
            led_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level       <= '0;
            state       <= ST_IDLE;
            full        <= 1'b0;
            led         <= '0;
            blink_count <= '0;
            blink_phase <= 1'b0;
        end else begin
            level       <= level_nxt;
            state       <= state_nxt;
            full        <= (level_nxt == LVL_FULL);
            led         <= led_nxt;
            blink_count <= blink_count_nxt;
            blink_phase <= blink_phase_nxt;
        end
    end

    assign busy = (level != target);

endmodule

// File: tb/tb_led_bar_meter.sv
// Bench for led_bar_meter: directed scenarios plus random loads/modes, all checked
// cycle by cycle against an arithmetic reference model through an expected-value queue.
module tb_led_bar_meter;

    localparam int WIDTH       = 8;
    localparam int VAL_W       = 8;
    localparam int OFFSET      = 16;
    localparam int TICK_DIV    = 4;
    localparam int BLINK_TICKS = 2;
    localparam int LVL_W       = 4;
    localparam int W           = WIDTH + LVL_W + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [VAL_W-1:0] value;
    logic [1:0]       mode;
    logic [WIDTH-1:0] led;
    logic [LVL_W-1:0] level;
    logic             full;
    logic             busy;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_tgt = 0, m_lvl = 0, m_dir = 0, m_phase = 0, m_bcnt = 0, m_since = 0;
    bit m_full = 1'b0;

    logic [WIDTH-1:0] seen_led[$];
    int seen_at[$];
    int max_lvl;

    led_bar_meter #(
        .WIDTH       (WIDTH),
        .VAL_W       (VAL_W),
        .OFFSET      (OFFSET),
        .TICK_DIV    (TICK_DIV),
        .BLINK_TICKS (BLINK_TICKS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .load  (load),
        .mode  (mode),
        .led   (led),
        .level (level),
        .full  (full),
        .busy  (busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int sgn(input int x);
        return (x > 0) ? 1 : ((x < 0) ? -1 : 0);
    endfunction

    function automatic logic [WIDTH-1:0] exp_bar(input int lvl, input int ph);
        int ones;
        if (ph != 0) return '0;
        ones = (1 << lvl) - 1;
        return WIDTH'(ones);
    endfunction

    always @(posedge clk) begin : model
        int t, d, new_lvl, new_dir, sat, v;
        bit hold;
        if (rst) begin
            m_tgt = 0; m_lvl = 0; m_dir = 0; m_phase = 0; m_bcnt = 0; m_since = 0;
            m_full = 1'b0;
            exp_q.push_back('0);
        end else begin
            t = (m_since > 0 && (m_since % TICK_DIV) == 0) ? 1 : 0;
            m_since++;
            v = int'(value);
            if (v < OFFSET) sat = 0;
            else sat = (v - OFFSET > WIDTH) ? WIDTH : v - OFFSET;
            if (mode == 2'd1 || mode == 2'd2) begin
                d = sgn(m_tgt - m_lvl);
                new_lvl = m_lvl + ((t == 1 && m_dir != 0 && d == m_dir) ? m_dir : 0);
                new_dir = sgn(m_tgt - new_lvl);
            end else begin
                new_lvl = m_tgt;
                new_dir = 0;
            end
            hold = (mode == 2'd2) && (new_lvl == WIDTH) && (new_dir == 0);
            if (!hold) begin
                m_bcnt = 0;
                m_phase = 0;
            end else if (t == 1 && m_full && m_dir == 0) begin
                if (m_bcnt == BLINK_TICKS - 1) begin
                    m_bcnt = 0;
                    m_phase = 1 - m_phase;
                end else begin
                    m_bcnt++;
                end
            end
            m_full = (new_lvl == WIDTH);
            m_lvl = new_lvl;
            m_dir = new_dir;
            if (load) m_tgt = sat;
            exp_q.push_back({exp_bar(m_lvl, m_phase), LVL_W'(m_lvl), m_full, m_lvl != m_tgt});
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        logic [W-1:0] got, want;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = {led, level, full, busy};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL cycle_check t=%0t: got led=%h level=%0d full=%b busy=%b, required led=%h level=%0d full=%b busy=%b",
                         $time, got[W-1 -: WIDTH], got[LVL_W+1:2], got[1], got[0],
                         want[W-1 -: WIDTH], want[LVL_W+1:2], want[1], want[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int v);
        value = VAL_W'(v);
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic go_zero(input logic [1:0] m);
        mode = 2'd0;
        do_load(0);
        step(1);
        mode = m;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic wait_lvl(input int lv, input string name);
        int n;
        n = 0;
        while (m_lvl != lv && n < 200) begin
            step(1);
            n++;
        end
        if (m_lvl != lv) check(name, 32'(m_lvl), 32'(lv));
    endtask

    task automatic watch(input int cycles);
        logic [WIDTH-1:0] prev;
        seen_led.delete();
        seen_at.delete();
        prev = led;
        max_lvl = int'(level);
        for (int j = 1; j <= cycles; j++) begin
            step(1);
            if (led !== prev) begin
                seen_led.push_back(led);
                seen_at.push_back(j);
                prev = led;
            end
            if (int'(level) > max_lvl) max_lvl = int'(level);
        end
    endtask

    function automatic logic [31:0] seen(input int i);
        return (i < seen_led.size()) ? 32'(seen_led[i]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] gap(input int i);
        return (i + 1 < seen_at.size()) ? 32'(seen_at[i+1] - seen_at[i]) : 32'hDEAD;
    endfunction

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int j, r, v;
        rst = 1'b1; load = 1'b0; value = '0; mode = 2'd0;
        step(3);
        check("reset_led", 32'(led), 32'h00);
        check("reset_level", 32'(level), 0);
        check("reset_full", 32'(full), 0);
        check("reset_busy", 32'(busy), 0);
        rst = 1'b0;
        step(1);

        // DIRECT saturation
        do_load(21);
        check("direct_latency_early_level", 32'(level), 0);
        step(1);
        check("direct_21_led", 32'(led), 32'h1F);
        check("direct_21_level", 32'(level), 5);
        do_load(10); step(1);
        check("direct_10_led", 32'(led), 32'h00);
        check("direct_10_busy", 32'(busy), 0);
        do_load(40); step(1);
        check("direct_40_led", 32'(led), 32'hFF);
        check("direct_40_full", 32'(full), 1);
        do_load(255); step(1);
        check("direct_255_led", 32'(led), 32'hFF);
        check("direct_255_level", 32'(level), 8);

        // reset mid-ramp, then tick counter restart
        go_zero(2'd1);
        do_load(24);
        wait_lvl(4, "rst_setup_timeout");
        rst = 1'b1;
        step(1);
        check("rst_mid_led", 32'(led), 32'h00);
        check("rst_mid_level", 32'(level), 0);
        check("rst_mid_full", 32'(full), 0);
        check("rst_mid_busy", 32'(busy), 0);
        step(2);
        value = 8'd19; load = 1'b1; rst = 1'b0;
        step(1);
        load = 1'b0;
        j = 1;
        while (level !== 4'd1 && j < 40) begin step(1); j++; end
        check("tick_restart_first_step_edge", 32'(j), 5);

        // RAMP rise and fall
        go_zero(2'd1);
        do_load(19);
        watch(40);
        check("ramp_rise_count", 32'(seen_led.size()), 3);
        check("ramp_rise_0", seen(0), 32'h01);
        check("ramp_rise_1", seen(1), 32'h03);
        check("ramp_rise_2", seen(2), 32'h07);
        check("ramp_rise_spacing", gap(0), TICK_DIV);
        check("ramp_rise_busy_done", 32'(busy), 0);
        do_load(17);
        check("ramp_fall_busy", 32'(busy), 1);
        watch(30);
        check("ramp_fall_count", 32'(seen_led.size()), 2);
        check("ramp_fall_0", seen(0), 32'h03);
        check("ramp_fall_1", seen(1), 32'h01);

        // RAMP reversal
        go_zero(2'd1);
        do_load(24);
        wait_lvl(3, "reversal_setup_timeout");
        do_load(17);
        watch(40);
        check("reversal_max_level", 32'(max_lvl), 3);
        check("reversal_seq_0", seen(0), 32'h03);
        check("reversal_seq_1", seen(1), 32'h01);
        check("reversal_final_level", 32'(level), 1);

        // RAMP_BLINK
        go_zero(2'd2);
        do_load(24);
        j = 0;
        while (full !== 1'b1 && j < 100) begin step(1); j++; end
        check("blink_full_reached", 32'(full), 1);
        check("blink_full_led", 32'(led), 32'hFF);
        watch(20);
        check("blink_first_blank", seen(0), 32'h00);
        check("blink_first_toggle_delay", seen_at.size() > 0 ? 32'(seen_at[0]) : 32'hDEAD,
              BLINK_TICKS * TICK_DIV);
        check("blink_relit", seen(1), 32'hFF);
        check("blink_half_period", gap(0), BLINK_TICKS * TICK_DIV);
        j = 0;
        while (led !== 8'h00 && j < 40) begin step(1); j++; end
        check("blink_wait_blank", 32'(led), 32'h00);
        do_load(20);
        check("blink_blank_on_load_edge", 32'(led), 32'h00);
        step(1);
        check("blink_clear_led", 32'(led), 32'hFF);
        watch(30);
        check("blink_fall_steps", 32'(seen_led.size()), 4);
        check("blink_fall_final", seen(3), 32'h0F);

        // load coincident with tick
        go_zero(2'd1);
        do_load(24);
        wait_lvl(4, "coincide_setup_timeout");
        j = 0;
        while (!(m_since > 0 && (m_since % TICK_DIV) == 0) && j < 10) begin step(1); j++; end
        do_load(17);
        check("coincide_old_target_step", 32'(level), 5);
        watch(30);
        check("coincide_final_level", 32'(level), 1);
        check("coincide_no_further_rise", 32'(max_lvl), 5);

        // RAMP -> DIRECT mid-ramp
        go_zero(2'd1);
        do_load(23);
        wait_lvl(2, "switch_setup_timeout");
        mode = 2'd0;
        step(1);
        check("switch_direct_led", 32'(led), 32'h7F);
        check("switch_direct_level", 32'(level), 7);

        // random phase, checked by the scoreboard
        for (int it = 0; it < 150; it++) begin
            r = int'($urandom_range(0, 9));
            mode = (r < 2) ? 2'd0 : ((r < 3) ? 2'd3 : ((r < 6) ? 2'd1 : 2'd2));
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                step(int'($urandom_range(1, 3)));
                rst = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) v = 255;
            else v = int'($urandom_range(0, 30));
            do_load(v);
            step(int'($urandom_range(0, 40)));
        end

        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_bar_meter.md
# led_bar_meter

Parametrised thermometer-style LED bar-graph driver for the scoreboard and basketball display path. Converts an offset-biased count value into a saturated bar level. In direct mode the bar jumps to the new level; in the animated modes it moves one LED per display tick toward the target. An optional mode blinks the whole bar while it is full.

## Interface
- `WIDTH`, default 8: number of LEDs in the bar; legal range 2..32.
- `VAL_W`, default 8: width of the input value.
- `OFFSET`, default 16: bias subtracted from `value` before display.
- `TICK_DIV`, default 1_000_000: clock cycles per animation tick; must be ≥2.
- `BLINK_TICKS`, default 25: ticks per blink half-period; must be ≥1.
- `clk`, in, 1: system clock. This is the only clock in the block.
- `rst`, in, 1: synchronous, active-high reset.
- `value`, in, VAL_W: raw count to display.
- `load`, in, 1: one-cycle strobe that samples `value` as the new target.
- `mode`, in, 2: 0 = DIRECT, 1 = RAMP, 2 = RAMP_BLINK. Code 3 is reserved and behaves as DIRECT.
- `led`, out, WIDTH: bar output; bit i lit means LED i is on.
- `level`, out, clog2(WIDTH+1): current bar level.
- `full`, out, 1: high when `level` == WIDTH.
- `busy`, out, 1: high when `level` ≠ target.

## Operation
- **Saturation.** `sat` = 0 if `value` < OFFSET. Otherwise `sat` = min(`value` − OFFSET, WIDTH). Compute the subtraction at VAL_W+1 bits so it never wraps.
- **Target register.** `target` is loaded with `sat` on any cycle where `load` = 1. Reset value is 0.
- **Bar encoding.** `led` = thermometer(`level`): bits [level−1:0] are 1, all others are 0. While blink phase is active, `led` = 0.
- **Tick generator.** A free-running counter runs 0..TICK_DIV−1. `tick` is a one-cycle registered pulse asserted when the counter wraps.
- **State machine.** States are IDLE, RISE and FALL.
  - IDLE: go to RISE if `target` > `level`; go to FALL if `target` < `level`.
  - RISE: on each `tick`, `level` increments by 1. Return to IDLE when `level` reaches `target`.
  - FALL: on each `tick`, `level` decrements by 1. Return to IDLE when `level` reaches `target`.
  - If `target` changes direction mid-move, the state switches direction on the next cycle; `level` never overshoots.
- **DIRECT mode.** `level` is set to `target` every cycle and the state machine is held in IDLE. Switching to DIRECT mid-ramp makes `level` jump to `target` on the next edge.
- **RAMP mode.** Stepping as described above. No blinking.
- **RAMP_BLINK mode.**
  - While `full` is high and the state is IDLE, a tick counter toggles `blink_phase` every BLINK_TICKS ticks.
  - `blink_phase` and the counter clear on the same edge on which `full` drops or `mode` ≠ RAMP_BLINK.
  - Phase starts at 0, meaning the bar is lit.
- **Simultaneous load and tick.** The step taken on that edge uses the old `target`. The new `target` governs from the next cycle.
- **`busy`.** Combinational compare of `level` against `target`.
- **`full`.** Registered alongside `level`.

## Timing
- **Reset.** `led`, `level`, `target`, the tick counter, the blink counter and `blink_phase` are all 0; `full` = 0; `busy` = 0; state = IDLE. Reset mid-ramp clears the bar on the same edge.
- **Registered outputs.** `led`, `level` and `full` are registered. `led` is computed from the next-state `level` and `blink_phase`, so `led` and `level` always agree in the same cycle.
- **DIRECT latency.** `load` at edge k → `target` valid after k → `level` and `led` valid after edge k+1 (2 cycles).
- **RAMP latency.** The first step occurs on the first `tick` edge at least 2 edges after the `load` edge. One LED changes per tick. A full 0→WIDTH sweep takes WIDTH ticks.
- **Blink timing.** The first toggle occurs BLINK_TICKS ticks after `full` rises.

## Structure
- **Package `led_bar_pkg`.** Holds the mode constants (MODE_DIRECT = 2'd0, MODE_RAMP = 2'd1, MODE_BLINK = 2'd2), the state encoding (IDLE, RISE, FALL), and a thermometer-encode function parametrised by WIDTH.
- **Sub-module `tick_gen`.** Parameter TICK_DIV; ports `clk`, `rst`, `tick`. It is instantiated once. It is also reusable for the shot-clock blinkers.
- **Main module.** Contains the saturation logic, target register, state machine, blink logic and output registers.

## Test plan
All scenarios use WIDTH=8, OFFSET=16, TICK_DIV=4, BLINK_TICKS=2.
1. Assert `rst` for 3 cycles mid-ramp (`level`=4) → next edge `led`=8'h00, `level`=0, `full`=0, `busy`=0; tick counter restarts at 0.
2. DIRECT saturation:
   - load 21 → 2 cycles later `led`=8'h1F, `level`=5.
   - load 10 → `led`=8'h00.
   - load 40 → `led`=8'hFF, `full`=1.
   - load 8'hFF → `led`=8'hFF, with no wrap.
3. RAMP rise and fall:
   - From 0, load 19 → `led` goes 01, 03, 07 on successive ticks (4 cycles apart); `busy` drops as `level` reaches 3.
   - Then load 17 → `led` goes 03, 01 over 2 ticks.
4. RAMP reversal: from 0, load 24. At `level`=3, load 17 → `level` goes 3→2→1 with no further rise and never overshoots.
5. RAMP_BLINK:
   - load 24 → after 8 ticks `full`=1, then `led` alternates FF/00 every 2 ticks.
   - load 20 mid-blank → `blink_phase` clears on the next edge, `led`=8'hFF, then falls to 8'h0F in 4 ticks.
6. Corner cases:
   - `load` coincident with `tick` → that step follows the old target; the new target applies from the next cycle.
   - Switching mode RAMP→DIRECT at `level`=2 with `target`=7 → `led`=8'h7F on the next edge.
